float_div_seq: RTL and testbench
================================

FLOAT_DIV_SEQ -- requirements
Module: float_div_seq

Interface
REQ-001 SHALL have parameter ITER_BITS, default 12, meaning the number of quotient bits produced, one per DIV cycle.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a divide; sampled only in IDLE.
REQ-005 SHALL have port floatA, input, 16 bits: dividend in half-precision layout {sign, exp[4:0], mant[9:0]}.
REQ-006 SHALL have port floatB, input, 16 bits: divisor, same layout.
REQ-007 SHALL have port quotient, output, 16 bits: registered result, held until the next accepted start.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when quotient becomes valid.

Function
REQ-010 SHALL implement states IDLE, DIV, NORM and DONE.
REQ-011 SHALL follow IDLE->DIV on start=1, DIV->NORM after ITER_BITS cycles, NORM->DONE, and DONE->IDLE unconditionally.
REQ-012 SHALL, on accepting start, capture floatA/floatB internally; later input changes SHALL NOT affect the operation.
REQ-013 SHALL ignore start when busy=1; no queuing.
REQ-014 SHALL assert done exactly ITER_BITS+2 cycles after the accepting edge (14 with the default), for one cycle, with quotient valid in that same cycle.
REQ-015 SHALL use the same latency for special-case operands; there is no fast path.
REQ-016 SHALL compute sign as floatA[15] XOR floatB[15].
REQ-017 SHALL form fractions {1, mant}, 11 bits; exponent field 0 gets the hidden 1 as well (no denormal handling).
REQ-018 SHALL compute exponent as signed 7-bit eA - eB + 15.
REQ-019 SHALL use restoring division for the quotient bits:
- remainder initialised to fracA, 12 bits;
- each DIV cycle: if rem >= fracB then qbit=1 and rem = rem - fracB, else qbit=0;
- then rem shifts left by 1;
- qbit shifts into q[0].
REQ-020 SHALL normalise in NORM:
- if q[11]=1: mant = q[10:1], exponent unchanged;
- else: mant = q[9:0], exponent - 1.
REQ-021 SHALL truncate the result; there is no rounding.
REQ-022 SHALL output 16'h0000 when the final exponent < 0 (underflow flush, sign dropped); an exponent field of 0 is emitted as-is.
REQ-023 SHALL saturate to {sign, 5'h1E, 10'h3FF} when the final exponent > 30.
REQ-024 SHALL treat an operand as zero iff bits[14:0] are all zero.
REQ-025 SHALL output 16'h0000 when A is zero; this takes priority over B zero.
REQ-026 SHALL output {sign, 5'h1F, 10'h000} when B is zero and A is non-zero.

Reset
REQ-027 SHALL, with rst=1 on a clock edge, set state=IDLE, quotient=16'h0000, busy=0, done=0, and clear the internal remainder and quotient registers.
REQ-028 SHALL, on reset during DIV or NORM, abort the operation with no done pulse; the next start after reset SHALL behave normally.
REQ-029 SHALL give rst priority over start in the same cycle.

Structure
REQ-030 SHALL take FP16_BIAS=15, EXP_W=5, MANT_W=10, EXP_MAX=30, and the INF and MAXNORM patterns from shared package float16_pkg, also usable by the multiplier.
REQ-031 SHALL take the state enum from float16_pkg.
REQ-032 SHALL contain no sub-module; the divide datapath is inline, with the only arithmetic being one 12-bit subtract/compare.

Verification
REQ-033 SHALL verify: 0x4200 / 0x3E00 (3.0/1.5) -> quotient 0x4000, done 14 cycles after start.
REQ-034 SHALL verify: 0x3C00 / 0x4200 (1/3) -> 0x3555 (truncated).
REQ-035 SHALL verify: 0xC200 / 0x3E00 -> 0xC000.
REQ-036 SHALL verify: 0x3C00 / 0x0000 -> 0x7C00.
REQ-037 SHALL verify:
- 0x0400 / 0x7800 -> 0x0000 (underflow);
- 0x7800 / 0x0400 -> 0x7BFF (saturate).
REQ-038 SHALL verify: start, then rst at cycle 5 -> busy=0 and quotient=0x0000 next cycle, no done; a following start with a re-pulse of start during busy -> exactly one done and a correct result.

Source files
------------

// File: rtl/float16_pkg.sv
// Shared half-precision constants and the sequencer state encoding used by
// the FP16 divide (and multiply) units.
package float16_pkg;

    localparam int FP16_BIAS = 15;
    localparam int EXP_W     = 5;
    localparam int MANT_W    = 10;
    localparam int EXP_MAX   = 30;

    // Magnitude patterns; the sign bit is prepended by the user.
    localparam logic [14:0] FP16_INF_MAG     = 15'h7C00;
    localparam logic [14:0] FP16_MAXNORM_MAG = 15'h7BFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_NORM,
        ST_DONE
    } fp_seq_state_e;

    function automatic logic fp16_is_zero(input logic [15:0] f);
        return f[14:0] == 15'h0000;
    endfunction

endpackage

// File: rtl/float_div_seq.sv
// Sequential FP16 divider: one restoring quotient bit per DIV cycle, then a
// single normalise/pack cycle. Truncating, no denormals, fixed latency.
//
// state   | meaning
// IDLE    | waiting for start; operands captured on the accepting edge
// DIV     | one restoring-division step per cycle, ITER_BITS cycles
// NORM    | normalise, apply special cases, register the result
// DONE    | done pulse; quotient valid
module float_div_seq
    import float16_pkg::*;
#(
    parameter int ITER_BITS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] floatA,
    input  logic [15:0] floatB,
    output logic [15:0] quotient,
    output logic        busy,
    output logic        done
);

    localparam int FRAC_W = MANT_W + 1;
    localparam int REM_W  = FRAC_W + 1;
    localparam int SEXP_W = EXP_W + 2;
    localparam int CNT_W  = $clog2(ITER_BITS + 1);

    localparam logic signed [SEXP_W-1:0] BIAS_S    = SEXP_W'(FP16_BIAS);
    localparam logic signed [SEXP_W-1:0] EXP_MAX_S = SEXP_W'(EXP_MAX);

    fp_seq_state_e r_state, w_next;

    logic [CNT_W-1:0]         r_cnt;
    logic [REM_W-1:0]         r_rem;
    logic [ITER_BITS-1:0]     r_q;
    logic [FRAC_W-1:0]        r_frac_b;
    logic signed [SEXP_W-1:0] r_exp;
    logic                     r_sign;
    logic                     r_a_zero;
    logic                     r_b_zero;
    logic [15:0]              r_quot;

    logic                     w_accept;
    logic                     w_busy;
    logic                     w_done;
    logic [REM_W:0]           w_sub;
    logic                     w_qbit;
    logic [REM_W-1:0]         w_rem_sel;
    logic signed [SEXP_W-1:0] w_exp_raw;
    logic signed [SEXP_W-1:0] w_exp_n;
    logic [MANT_W-1:0]        w_mant;
    logic [15:0]              w_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b1;
        w_done = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start) w_next = ST_DIV;
            end
            ST_DIV:  if (r_cnt == '0) w_next = ST_NORM;
            ST_NORM: w_next = ST_DONE;
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_accept = (r_state == ST_IDLE) && start;

    // The single subtractor: its borrow is the compare, its difference the new remainder.
    assign w_sub     = {1'b0, r_rem} - {2'b00, r_frac_b};
    assign w_qbit    = ~w_sub[REM_W];
    assign w_rem_sel = w_qbit ? w_sub[REM_W-1:0] : r_rem;

    assign w_exp_raw = $signed({2'b00, floatA[14 -: EXP_W]})
                     - $signed({2'b00, floatB[14 -: EXP_W]}) + BIAS_S;

    always_comb begin
        w_mant  = r_q[ITER_BITS-3 -: MANT_W];
        w_exp_n = r_exp - SEXP_W'(1);
        if (r_q[ITER_BITS-1]) begin
            w_mant  = r_q[ITER_BITS-2 -: MANT_W];
            w_exp_n = r_exp;
        end
        if (r_a_zero) begin
            w_result = 16'h0000;
        end else if (r_b_zero) begin
            w_result = {r_sign, FP16_INF_MAG};
        end else if (w_exp_n[SEXP_W-1]) begin
            w_result = 16'h0000;
        end else if (w_exp_n > EXP_MAX_S) begin
            w_result = {r_sign, FP16_MAXNORM_MAG};
        end else begin
            w_result = {r_sign, w_exp_n[EXP_W-1:0], w_mant};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_frac_b <= '0;
            r_exp    <= '0;
            r_sign   <= 1'b0;
            r_a_zero <= 1'b0;
            r_b_zero <= 1'b0;
            r_quot   <= 16'h0000;
        end else if (w_accept) begin
            r_cnt    <= CNT_W'(ITER_BITS - 1);
            r_rem    <= {1'b0, 1'b1, floatA[MANT_W-1:0]};
            r_q      <= '0;
            r_frac_b <= {1'b1, floatB[MANT_W-1:0]};
            r_exp    <= w_exp_raw;
            r_sign   <= floatA[15] ^ floatB[15];
            r_a_zero <= fp16_is_zero(floatA);
            r_b_zero <= fp16_is_zero(floatB);
        end else if (r_state == ST_DIV) begin
            // The kept remainder is always below the divisor, so its MSB is free to shift out.
            r_rem <= {w_rem_sel[REM_W-2:0], 1'b0};
            r_q   <= {r_q[ITER_BITS-2:0], w_qbit};
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end else if (r_state == ST_NORM) begin
            r_quot <= w_result;
        end
    end

    assign quotient = r_quot;
    assign busy     = w_busy;
    assign done     = w_done;

endmodule

// File: tb/tb_float_div_seq.sv
// Self-checking bench for float_div_seq: directed cases, reset abort, and a
// randomized run compared every cycle against a cycle-timeline reference model.
module tb_float_div_seq;

    localparam int ITER = 12;
    localparam int LAT  = ITER + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] floatA = 16'h0000;
    logic [15:0] floatB = 16'h0000;
    logic [15:0] quotient;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    float_div_seq #(.ITER_BITS(ITER)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .floatA   (floatA),
        .floatB   (floatB),
        .quotient (quotient),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact truncated quotient with 11 fraction bits, then pack.
    function automatic logic [15:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        int  fa, fb, q, e, mant;
        logic s;
        s = a[15] ^ b[15];
        if (a[14:0] == 15'h0) return 16'h0000;
        if (b[14:0] == 15'h0) return {s, 15'h7C00};
        fa = 1024 + int'(a[9:0]);
        fb = 1024 + int'(b[9:0]);
        q  = (fa * 2048) / fb;
        e  = int'(a[14:10]) - int'(b[14:10]) + 15;
        if (q >= 2048) begin
            mant = (q / 2) % 1024;
        end else begin
            mant = q % 1024;
            e    = e - 1;
        end
        if (e < 0) return 16'h0000;
        if (e > 30) return {s, 15'h7BFF};
        return {s, 5'(e), 10'(mant)};
    endfunction

    function automatic logic [15:0] rnd_op();
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(7) == 0) v[14:0] = 15'h0;
        else if ($urandom_range(1) == 0) v[14:10] = 5'($urandom_range(20, 10));
        return v;
    endfunction

    // Timeline model: cycles remaining until idle; 1 means the done cycle.
    int          m_cnt  = 0;
    logic [15:0] m_pend = 16'h0000;
    logic [15:0] m_quot = 16'h0000;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  <= 0;
            m_quot <= 16'h0000;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt  <= LAT;
                m_pend <= ref_div(floatA, floatB);
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) m_quot <= m_pend;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_cnt != 0));
            chk("done", 32'(done), 32'(m_cnt == 1));
            chk("quotient", 32'(quotient), 32'(m_quot));
        end
    end

    // Window index 1 is the cycle right after the accepting edge; done must be
    // high in window LAT, i.e. sampled true by the LAT-th edge after acceptance.
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp);
        int  cyc;
        bit  seen;
        @(negedge clk);
        floatA = a;
        floatB = b;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        floatA = 16'($urandom);
        floatB = 16'($urandom);
        cyc  = 1;
        seen = 1'b0;
        while (cyc <= 40) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (!seen) begin
            chk({name, "_done_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, "_latency"}, 32'(cyc), 32'(LAT));
            chk({name, "_q"}, 32'(quotient), 32'(exp));
        end
    endtask

    int          dones;
    logic [15:0] q_at_done;

    initial begin
        #(400000 * 10);
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        chk("model_pin_third", 32'(ref_div(16'h3C00, 16'h4200)), 32'h3555);
        chk("model_pin_sat", 32'(ref_div(16'h7800, 16'h0400)), 32'h7BFF);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_q", 32'(quotient), 32'h0000);
        chk_en = 1'b1;

        run_op("three_by_1p5", 16'h4200, 16'h3E00, 16'h4000);
        run_op("one_third",    16'h3C00, 16'h4200, 16'h3555);
        run_op("neg",          16'hC200, 16'h3E00, 16'hC000);
        run_op("div_zero",     16'h3C00, 16'h0000, 16'h7C00);
        run_op("zero_zero",    16'h0000, 16'h0000, 16'h0000);
        run_op("underflow",    16'h0400, 16'h7800, 16'h0000);
        run_op("saturate",     16'h7800, 16'h0400, 16'h7BFF);

        // Abort: reset in the fifth cycle of an operation.
        @(negedge clk);
        floatA = 16'h4200;
        floatB = 16'h3E00;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_q", 32'(quotient), 32'h0000);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);

        // Start again, re-pulsing start mid-operation: exactly one done.
        floatA = 16'h3C00;
        floatB = 16'h4200;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        q_at_done = 16'h0000;
        for (int i = 0; i < 30; i++) begin
            if (i == 4) begin
                start  = 1'b1;
                floatA = 16'h7800;
                floatB = 16'h0400;
            end
            if (i == 5) start = 1'b0;
            if (done) begin
                dones++;
                q_at_done = quotient;
            end
            @(negedge clk);
        end
        chk("repulse_one_done", 32'(dones), 32'd1);
        chk("repulse_q", 32'(q_at_done), 32'h3555);

        // Random phase: model comparison every cycle, occasional resets.
        for (int i = 0; i < 3000; i++) begin
            start  = ($urandom_range(3) == 0);
            floatA = rnd_op();
            floatB = rnd_op();
            rst    = ($urandom_range(299) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (LAT + 4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
